// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide engine.
// Optional build macro: UNSIGNED_OPS_EN (enables MULTU/DIVU via op[1]).
package muldiv_pkg;

    // Default operand/result word width.
    localparam int WIDTH_DEF = 32;

    // Bit positions inside the 2-bit op field.
    localparam int OP_KIND_BIT = 0;  // 0 = MULT, 1 = DIV
    localparam int OP_UNS_BIT  = 1;  // unsigned select (feature build only)

    // Values of op[OP_KIND_BIT].
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // Controller state encoding (3-bit).
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_RUN   = 3'd2,
        ST_FIX   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ZDIV  = 3'd5
    } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Accumulators, adder/subtractor and sign-correction negators for the
// multiply/divide engine. Driven by load/init/step/fix enables from the
// sequencer. Optional build macro: UNSIGNED_OPS_EN.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,       // synchronous, active low
    input  logic             load,        // capture operands (IDLE + start)
    input  logic             uns_req,     // op[1] at load time
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             is_div,      // latched op kind
    input  logic             init,        // clear/seed accumulators (CHECK)
    input  logic             step,        // one iteration (RUN)
    input  logic             fix,         // sign correction + result register (FIX)
    output logic             divisor_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic             uns_sel;
    logic             sign_a_d, sign_b_d;
    logic [WIDTH-1:0] mag_a_d, mag_b_d;

    logic             sign_a_q, sign_b_q;
    logic [WIDTH-1:0] mag_a_q, mag_b_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
    logic [WIDTH-1:0] hi_q, lo_q;

`ifdef UNSIGNED_OPS_EN
    assign uns_sel = uns_req;
`else
    // All operations are signed; op[1] has no effect in this build.
    logic unused_uns_req;
    assign unused_uns_req = uns_req;
    assign uns_sel        = 1'b0;
`endif

    // Operand sign flags and magnitudes; the most negative value maps to
    // itself, which is the correct magnitude when read as unsigned.
    assign sign_a_d = rs_val[WIDTH-1] & ~uns_sel;
    assign sign_b_d = rt_val[WIDTH-1] & ~uns_sel;
    assign mag_a_d  = sign_a_d ? ({WIDTH{1'b0}} - rs_val) : rs_val;
    assign mag_b_d  = sign_b_d ? ({WIDTH{1'b0}} - rt_val) : rt_val;

    assign divisor_zero = (mag_b_q == {WIDTH{1'b0}});

    // Multiply iteration: conditional add with carry, then shift right.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}});

    // Divide iteration: shift {rem,quo} left, trial-subtract the divisor.
    // The partial remainder always stays below the divisor, so the
    // difference fits in WIDTH bits.
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff;
    assign rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign rem_ge   = (rem_sh >= {1'b0, mag_b_q});
    assign rem_diff = rem_sh[WIDTH-1:0] - mag_b_q;

    // Sign correction of the final accumulator contents.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = (sign_a_q ^ sign_b_q) ? ({(2*WIDTH){1'b0}} - prod) : prod;
    assign quo_fix  = (sign_a_q ^ sign_b_q) ? ({WIDTH{1'b0}} - acc_lo_q) : acc_lo_q;
    assign rem_fix  = sign_a_q ? ({WIDTH{1'b0}} - acc_hi_q) : acc_hi_q;

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (load) begin
                sign_a_q <= sign_a_d;
                sign_b_q <= sign_b_d;
                mag_a_q  <= mag_a_d;
                mag_b_q  <= mag_b_d;
            end
            if (init) begin
                acc_hi_q <= '0;
                acc_lo_q <= is_div ? mag_a_q : mag_b_q;
            end else if (step) begin
                if (is_div) begin
                    acc_hi_q <= rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
                    acc_lo_q <= {acc_lo_q[WIDTH-2:0], rem_ge};
                end else begin
                    acc_hi_q <= mul_sum[WIDTH:1];
                    acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
            end
            if (fix) begin
                if (is_div) begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end else begin
                    hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                    lo_q <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Controller for the iterative MULT/DIV engine: accepts a start request,
// runs WIDTH shift-add / restoring-divide iterations in muldiv_datapath,
// and emits done + HI/LO write strobes or a divide-by-zero pulse.
// Optional build macro: UNSIGNED_OPS_EN (op[1] selects MULTU/DIVU).
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,      // synchronous, active low
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [2:0]       dbg_state   // current controller state
);

    // Handshake: start is a level sampled only while IDLE; acceptance is
    // visible as busy=1 the next cycle. done/div0 are single-cycle pulses
    // with no back-pressure; results stay on hi_out/lo_out until replaced.

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             op_div_q;
    logic             busy_q, done_q, div0_q;

    logic dp_load, dp_init, dp_step, dp_fix;
    logic divisor_zero;

    assign dp_load = (state_q == ST_IDLE) && start;
    assign dp_init = (state_q == ST_CHECK) && !(op_div_q && divisor_zero);
    assign dp_step = (state_q == ST_RUN);
    assign dp_fix  = (state_q == ST_FIX);

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk          (clk),
        .reset        (reset),
        .load         (dp_load),
        .uns_req      (op[OP_UNS_BIT]),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .is_div       (op_div_q),
        .init         (dp_init),
        .step         (dp_step),
        .fix          (dp_fix),
        .divisor_zero (divisor_zero),
        .hi_out       (hi_out),
        .lo_out       (lo_out)
    );

    // Controller FSM with iteration counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_div_q <= (op[OP_KIND_BIT] == OP_DIV);
                        busy_q   <= 1'b1;
                        state_q  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (op_div_q && divisor_zero) begin
                        busy_q  <= 1'b0;
                        div0_q  <= 1'b1;
                        state_q <= ST_ZDIV;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                ST_ZDIV: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div0      = div0_q;
    assign hi_we     = done_q;
    assign lo_we     = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed, table-driven bench for muldiv_sequencer with hand-written
// sequences for divide-by-zero, ignored starts and mid-operation reset.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_val, rt_val;
    logic         busy, done, div0, hi_we, lo_we;
    logic [W-1:0] hi_out, lo_out;
    logic [2:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .busy      (busy),
        .done      (done),
        .div0      (div0),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and check latency, strobes and results.
    // poke: pulse start mid-run and again during the done cycle; both must be ignored.
    task automatic run_op(input string tag, input logic [1:0] op_v, input logic [W-1:0] rs_v,
                          input logic [W-1:0] rt_v, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input bit poke);
        int cyc;
        int bad;
        @(negedge clk);
        start  = 1'b1;
        op     = op_v;
        rs_val = rs_v;
        rt_val = rt_v;
        @(negedge clk);
        cyc = 1;
        bad = 0;
        start = 1'b0;
        check({tag, " busy@1"}, {31'd0, busy}, 32'd1);
        // Operands changing after acceptance must not matter.
        rs_val = $urandom;
        rt_val = $urandom_range(1, 1000);
        while (done !== 1'b1 && cyc < 60) begin
            if (busy !== 1'b1 || hi_we !== 1'b0 || div0 !== 1'b0) bad++;
            if (poke && cyc == 5) begin
                start = 1'b1;
                op    = ~op_v;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd35);
        check({tag, " run status"}, 32'(bad), 32'd0);
        check({tag, " hi_we"}, {31'd0, hi_we}, 32'd1);
        check({tag, " lo_we"}, {31'd0, lo_we}, 32'd1);
        check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
        check({tag, " hi"}, hi_out, exp_hi);
        check({tag, " lo"}, lo_out, exp_lo);
        if (poke) begin
            start  = 1'b1;
            op     = 2'b00;
            rs_val = 32'd3;
            rt_val = 32'd3;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, " done pulse"}, {31'd0, done}, 32'd0);
        check({tag, " we pulse"}, {31'd0, hi_we | lo_we}, 32'd0);
        if (poke) begin
            check({tag, " start in DONE ignored"}, {31'd0, busy}, 32'd0);
            check({tag, " back to idle"}, {29'd0, dbg_state}, 32'd0);
            check({tag, " hi kept"}, hi_out, exp_hi);
        end
    endtask

    initial begin
        // Table: op, rs, rt, expected HI, expected LO.
        vecs[0] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{2'b01, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[3] = '{2'b01, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[4] = '{2'b01, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[5] = '{2'b01, 32'hFFFF_FFF8, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        vecs[6] = '{2'b01, 32'h0000_0005, 32'h0000_000A, 32'h0000_0005, 32'h0000_0000};
        vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{2'b00, 32'h0000_FFFF, 32'h0001_0001, 32'h0000_0000, 32'hFFFF_FFFF};
`ifdef UNSIGNED_OPS_EN
        vecs[9] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
`else
        vecs[9] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
`endif

        // Reset block.
        reset  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = '0;
        rt_val = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset strobes", {27'd0, done, div0, hi_we, lo_we, 1'b0}, 32'd0);
        check("reset hi", hi_out, 32'd0);
        check("reset lo", lo_out, 32'd0);
        check("reset state", {29'd0, dbg_state}, 32'd0);
        reset = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].exp_hi, vecs[i].exp_lo, 1'b0);
        end

        // Extra starts while busy and during done are ignored.
        run_op("mult max poke", 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
               32'h3FFF_FFFF, 32'h0000_0001, 1'b1);

        // Divide by zero: div0 pulse at cycle 2, results untouched.
        @(negedge clk);
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'h0000_1234;
        rt_val = 32'h0000_0000;
        @(negedge clk);
        start = 1'b0;
        check("zdiv div0@1", {31'd0, div0}, 32'd0);
        check("zdiv busy@1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("zdiv div0@2", {31'd0, div0}, 32'd1);
        check("zdiv busy@2", {31'd0, busy}, 32'd0);
        check("zdiv no done", {29'd0, done, hi_we, lo_we}, 32'd0);
        check("zdiv hi kept", hi_out, 32'h3FFF_FFFF);
        check("zdiv lo kept", lo_out, 32'h0000_0001);
        @(negedge clk);
        check("zdiv div0 pulse", {31'd0, div0}, 32'd0);
        check("zdiv idle", {29'd0, dbg_state}, 32'd0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        start  = 1'b1;
        op     = 2'b00;
        rs_val = 32'd5;
        rt_val = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset hi", hi_out, 32'd0);
        check("midreset lo", lo_out, 32'd0);
        check("midreset state", {29'd0, dbg_state}, 32'd0);
        reset = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (done === 1'b1 || hi_we === 1'b1 || busy === 1'b1) seen++;
            end
            check("midreset no done", 32'(seen), 32'd0);
        end
        run_op("after reset", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Time limit for the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide engine and its controller. Serves MULT and DIV for the multicycle control FSM.
- Accepts a start request with rs/rt operands and runs a 32-iteration shift-add multiply or restoring divide.
- Produces HI/LO write strobes plus a done pulse.
- Raises a divide-by-zero exception flag, which the main FSM routes to its ZeroDiv handling state.

Parameters:
- WIDTH, 32, operand/result word width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous active-low reset: when reset==0 at a posedge, all state returns to reset values.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  2  op[0]: 0=MULT, 1=DIV. op[1]: unsigned select, used only with UNSIGNED_OPS_EN, otherwise ignored.
- rs_val  in  WIDTH  multiplicand / dividend.
- rt_val  in  WIDTH  multiplier / divisor.
- busy  out  1  high from the cycle after start is accepted until done/div0 is asserted.
- done  out  1  one-cycle pulse; HI/LO results are valid.
- div0  out  1  one-cycle pulse; DIV with rt_val==0.
- hi_we  out  1  one-cycle HI write strobe, coincident with done.
- lo_we  out  1  one-cycle LO write strobe, coincident with done.
- hi_out  out  WIDTH  MULT: upper product. DIV: remainder.
- lo_out  out  WIDTH  MULT: lower product. DIV: quotient.

Behaviour:
- Reset values: busy=0, done=0, div0=0, hi_we=0, lo_we=0, hi_out=0, lo_out=0; state=IDLE; counter=0.
- Reset wins over every other event, including reset mid-operation. The in-flight operation is discarded and no strobes are emitted.
- IDLE:
  - start=1 latches op, rs_val, rt_val.
  - Latches sign flags: sA=rs[31], sB=rt[31], with signed ops only.
  - Latches magnitudes |rs|, |rt|; magnitude of 0x80000000 is 0x80000000 treated as unsigned.
  - Next state: CHECK.
- CHECK (1 cycle):
  - DIV with rt==0 -> ZDIV.
  - Otherwise load accumulator/counter=0 -> RUN.
- RUN (exactly WIDTH cycles, counter 0..WIDTH-1):
  - MULT: if acc_lo[0], add multiplicand to acc_hi (with carry); shift {carry,acc_hi,acc_lo} right 1.
  - DIV: shift {rem,quo} left 1; if rem>=|divisor|, rem-=|divisor| and quo[0]=1.
  - After counter==WIDTH-1 -> FIX.
- FIX (1 cycle), sign correction:
  - MULT: if sA^sB, 64-bit two's-complement negate.
  - DIV: quotient negated if sA^sB; remainder negated if sA (remainder takes dividend's sign).
  - Register hi_out/lo_out -> DONE.
- DONE (1 cycle): done=hi_we=lo_we=1 -> IDLE.
- ZDIV (1 cycle): div0=1; hi_out/lo_out and strobes untouched -> IDLE.
- Latency:
  - start accepted at cycle 0; done asserted at cycle 35 (CHECK 1 + RUN 32 + FIX 1 + DONE).
  - div0 asserted at cycle 2.
  - Next start accepted in the cycle done/div0 is high? No: only after return to IDLE, i.e. the following cycle.
- start while not IDLE: ignored, no queuing. Operand changes after acceptance have no effect.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0, no exception. Wrap semantics.
- busy=1 in CHECK, RUN, FIX; busy=0 in DONE, ZDIV, IDLE.

Optional Feature:
- Macro UNSIGNED_OPS_EN.
- Defined: op[1]=1 selects MULTU/DIVU. Sign flags are forced 0, operands are used raw, and FIX performs no negation.
- Undefined: op[1] is ignored and all operations are signed.

Decomposition:
- Shared package muldiv_pkg:
  - state encoding constants (IDLE, CHECK, RUN, FIX, DONE, ZDIV; 3-bit);
  - OP_MULT/OP_DIV bit definitions;
  - WIDTH default.
- One natural sub-module: muldiv_datapath. It holds the accumulators, adder/subtractor and negators, driven by the sequencer's load/step/fix enables. The FSM and counter stay in muldiv_sequencer.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3) -> done at cycle 35, HI=0xFFFFFFFF, LO=0xFFFFFFEB, hi_we=lo_we=1 for 1 cycle.
- MULT rs=rt=0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001; a second start during busy is ignored and results are unchanged.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV rt=0 -> div0 pulse at cycle 2, done/hi_we/lo_we stay 0, hi_out/lo_out retain previous values.
- Start MULT, drive reset=0 at cycle 10 -> next cycle busy=0, all outputs 0, no done ever asserted. A new start after release completes normally.
- With UNSIGNED_OPS_EN: op=2'b10, rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Without the macro, the same stimulus gives HI=0, LO=1.
